// File: rtl/branch_target_buffer_if.sv
//------------------------------------------------------------------------------
// Module   : branch_target_buffer_if
// Purpose  : Lookup (IF) and training (EX) signal bundle for the BTB.
//            master = fetch/execute pipeline side, slave = the BTB itself.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface branch_target_buffer_if;
    // IF-stage lookup
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    // EX-stage training
    logic        ex_update;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_mispredicted;

    modport master (
        output if_pc,
        output ex_update, ex_pc, ex_taken, ex_target, ex_mispredicted,
        input  pred_hit, pred_taken, pred_target
    );

    modport slave (
        input  if_pc,
        input  ex_update, ex_pc, ex_taken, ex_target, ex_mispredicted,
        output pred_hit, pred_taken, pred_target
    );
endinterface

`default_nettype wire

// File: rtl/branch_target_buffer.sv
//------------------------------------------------------------------------------
// Module   : branch_target_buffer
// Purpose  : Direct-mapped branch target buffer with a 2-bit direction state
//            per entry. Combinational lookup of the fetch PC, registered
//            training from EX. Optional statistics counters are compiled in
//            when the macro BTB_STATS_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_target_buffer #(
    parameter int ENTRIES    = 64,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 24
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    branch_target_buffer_if.slave  btb
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]            stat_hits,
    output logic [31:0]            stat_updates,
    output logic [31:0]            stat_mispredicts
`endif
);

    // Direction state encodings; bit 1 set means "predict taken"
    typedef enum logic [1:0] {
        STRONG_NOT_TAKEN = 2'b00,
        WEAK_NOT_TAKEN   = 2'b01,
        WEAK_TAKEN       = 2'b10,
        STRONG_TAKEN     = 2'b11
    } state_t;

    // Table storage, all flops
    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    state_t              state_q  [ENTRIES];

    // Address decomposition; pc[1:0] never participates
    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0]   if_tag;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0]   ex_tag;
    logic                  ex_hit;
    state_t                state_cur;
    state_t                state_d;

    assign if_idx = btb.if_pc[INDEX_BITS+1:2];
    assign if_tag = btb.if_pc[31:INDEX_BITS+2];
    assign ex_idx = btb.ex_pc[INDEX_BITS+1:2];
    assign ex_tag = btb.ex_pc[31:INDEX_BITS+2];

    // Lookup reads current contents only, so a same-cycle write is not bypassed
    always_comb begin
        btb.pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        btb.pred_taken  = btb.pred_hit &&
                          ((state_q[if_idx] == STRONG_TAKEN) ||
                           (state_q[if_idx] == WEAK_TAKEN));
        btb.pred_target = btb.pred_taken ? target_q[if_idx] : 32'h0;
    end

    assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign state_cur = state_q[ex_idx];

    // Direction FSM next state for the entry being trained
    always_comb begin
        state_d = state_cur;
        unique case (state_cur)
            STRONG_NOT_TAKEN: state_d = btb.ex_mispredicted ? WEAK_NOT_TAKEN   : STRONG_NOT_TAKEN;
            WEAK_NOT_TAKEN:   state_d = btb.ex_mispredicted ? STRONG_TAKEN     : STRONG_NOT_TAKEN;
            STRONG_TAKEN:     state_d = btb.ex_mispredicted ? WEAK_TAKEN       : STRONG_TAKEN;
            WEAK_TAKEN:       state_d = btb.ex_mispredicted ? STRONG_NOT_TAKEN : STRONG_TAKEN;
            default:          state_d = state_cur;
        endcase
    end

    // Table write: train on hit, allocate only taken misses; reset clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                state_q[i]  <= STRONG_NOT_TAKEN;
            end
        end else if (btb.ex_update) begin
            if (ex_hit) begin
                state_q[ex_idx] <= state_d;
                if (btb.ex_taken) begin
                    target_q[ex_idx] <= btb.ex_target;
                end
            end else if (btb.ex_taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= btb.ex_target;
                state_q[ex_idx]  <= WEAK_TAKEN;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] updates_q;
    logic [31:0] mispredicts_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q        <= 32'h0;
            updates_q     <= 32'h0;
            mispredicts_q <= 32'h0;
        end else begin
            if (btb.pred_hit && (hits_q != 32'hFFFF_FFFF)) begin
                hits_q <= hits_q + 32'd1;
            end
            if (btb.ex_update && (updates_q != 32'hFFFF_FFFF)) begin
                updates_q <= updates_q + 32'd1;
            end
            if (btb.ex_update && btb.ex_mispredicted && (mispredicts_q != 32'hFFFF_FFFF)) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_hits        = hits_q;
    assign stat_updates     = updates_q;
    assign stat_mispredicts = mispredicts_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
//------------------------------------------------------------------------------
// Module   : tb_branch_target_buffer
// Purpose  : Directed self-checking bench for branch_target_buffer.
//            Statistics checks are compiled when BTB_STATS_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_target_buffer;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    branch_target_buffer_if bus ();

`ifdef BTB_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    branch_target_buffer #(
        .ENTRIES    (64),
        .INDEX_BITS (6),
        .TAG_BITS   (24)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .btb              (bus.slave)
`ifdef BTB_STATS_EN
        ,
        .stat_hits        (stat_hits),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle training pulse, committed at the next rising edge
    task automatic train(input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic mis);
        bus.ex_update       = 1'b1;
        bus.ex_pc           = pc;
        bus.ex_taken        = tk;
        bus.ex_target       = tgt;
        bus.ex_mispredicted = mis;
        tick();
        bus.ex_update       = 1'b0;
        bus.ex_mispredicted = 1'b0;
    endtask

    // Combinational lookup check
    task automatic look(input string tag, input logic [31:0] pc,
                        input logic hit, input logic tk, input logic [31:0] tgt);
        bus.if_pc = pc;
        #1;
        check({tag, ".hit"},    {31'h0, bus.pred_hit},   {31'h0, hit});
        check({tag, ".taken"},  {31'h0, bus.pred_taken}, {31'h0, tk});
        check({tag, ".target"}, bus.pred_target,         tgt);
    endtask

    initial begin
        n_total             = 0;
        n_bad               = 0;
        rst_n               = 1'b0;
        bus.if_pc           = 32'h100;
        bus.ex_update       = 1'b0;
        bus.ex_pc           = 32'h0;
        bus.ex_taken        = 1'b0;
        bus.ex_target       = 32'h0;
        bus.ex_mispredicted = 1'b0;

        // Reset state
        #2;
        look("reset", 32'h100, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        look("post_reset", 32'h100, 1'b0, 1'b0, 32'h0);

        // Allocate on taken miss -> WEAK_TAKEN
        train(32'h100, 1'b1, 32'h200, 1'b1);
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

        // WT --mis--> SNT (target kept, not shown)
        train(32'h100, 1'b0, 32'h0, 1'b1);
        look("to_snt", 32'h100, 1'b1, 1'b0, 32'h0);
        // SNT --mis--> WNT
        train(32'h100, 1'b1, 32'h200, 1'b1);
        look("to_wnt", 32'h100, 1'b1, 1'b0, 32'h0);
        // WNT --mis--> ST
        train(32'h100, 1'b1, 32'h200, 1'b1);
        look("to_st", 32'h100, 1'b1, 1'b1, 32'h200);
        // ST --ok--> ST, taken hit refreshes target
        train(32'h100, 1'b1, 32'h204, 1'b0);
        look("st_hold", 32'h100, 1'b1, 1'b1, 32'h204);
        // ST --mis--> WT (still taken)
        train(32'h100, 1'b1, 32'h208, 1'b1);
        look("to_wt", 32'h100, 1'b1, 1'b1, 32'h208);

        // Alias at index 0 evicts old entry
        train(32'h200, 1'b1, 32'h300, 1'b1);
        look("evicted", 32'h100, 1'b0, 1'b0, 32'h0);
        look("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);

        // Not-taken miss does not allocate and leaves the resident entry
        train(32'h500, 1'b0, 32'h0, 1'b0);
        look("nt_miss", 32'h500, 1'b0, 1'b0, 32'h0);
        look("nt_keep", 32'h200, 1'b1, 1'b1, 32'h300);

        // Same-cycle lookup and allocate: no bypass
        bus.if_pc           = 32'h400;
        bus.ex_update       = 1'b1;
        bus.ex_pc           = 32'h400;
        bus.ex_taken        = 1'b1;
        bus.ex_target       = 32'h480;
        bus.ex_mispredicted = 1'b1;
        #1;
        check("same_cycle.hit", {31'h0, bus.pred_hit}, 32'h0);
        tick();
        bus.ex_update       = 1'b0;
        bus.ex_mispredicted = 1'b0;
        look("next_cycle", 32'h400, 1'b1, 1'b1, 32'h480);
        // Low PC bits are ignored on both sides
        look("low_bits", 32'h403, 1'b1, 1'b1, 32'h480);

        // Clean table for counting
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.if_pc = 32'hF00;
        tick();
`ifdef BTB_STATS_EN
        check("stat0.hits", stat_hits, 32'd0);
`endif
        train(32'h600, 1'b1, 32'h640, 1'b1);
        train(32'h604, 1'b1, 32'h644, 1'b1);
        train(32'h608, 1'b0, 32'h0,   1'b0);
        train(32'h60C, 1'b0, 32'h0,   1'b0);
        bus.if_pc = 32'h600;
        tick();
        tick();
        tick();
        bus.if_pc = 32'hF00;
        tick();
`ifdef BTB_STATS_EN
        check("stat.hits",        stat_hits,        32'd3);
        check("stat.updates",     stat_updates,     32'd4);
        check("stat.mispredicts", stat_mispredicts, 32'd2);
`endif
        look("entry_604", 32'h604, 1'b1, 1'b1, 32'h644);

        // Reset in the middle of a pending update
        bus.if_pc           = 32'h600;
        bus.ex_update       = 1'b1;
        bus.ex_pc           = 32'h700;
        bus.ex_taken        = 1'b1;
        bus.ex_target       = 32'h740;
        bus.ex_mispredicted = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.hit", {31'h0, bus.pred_hit}, 32'h0);
`ifdef BTB_STATS_EN
        check("midrst.hits",        stat_hits,        32'd0);
        check("midrst.updates",     stat_updates,     32'd0);
        check("midrst.mispredicts", stat_mispredicts, 32'd0);
`endif
        tick();
        bus.ex_update       = 1'b0;
        bus.ex_mispredicted = 1'b0;
        rst_n = 1'b1;
        tick();
        look("midrst.old", 32'h600, 1'b0, 1'b0, 32'h0);
        look("midrst.pending", 32'h700, 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
